// File: rtl/gate_tester.sv
// Automatic gate tester: sweeps every stimulus pattern across CHANNELS gate
// inputs, compares the synchronised responses and keeps per-channel error counts.
module gate_tester #(
   parameter int CHANNELS      = 6,
   parameter int SETTLE_CYCLES = 4,
   parameter int ERR_W         = 4,
   parameter int FAIL_THRESH   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                invert,
   input  logic [CHANNELS-1:0] resp,
   output logic [CHANNELS-1:0] stim,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CHANNELS-1:0] fail_flag,
   output logic [CHANNELS-1:0] diff
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [ERR_W-1:0]    ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [CHANNELS-1:0] STIM_MAX = {CHANNELS{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                          state_r, state_s;
   logic [CHANNELS-1:0]             sync1_r, sync2_r;
   logic [CHANNELS-1:0]             stim_r, stim_s;
   logic [CNT_W-1:0]                cnt_r, cnt_s;
   logic                            mode_r, mode_s;
   logic [CHANNELS-1:0][ERR_W-1:0]  err_r, err_s;
   logic [CHANNELS-1:0]             fail_r, fail_s;
   logic [CHANNELS-1:0]             diff_r, diff_s;
   logic [CHANNELS-1:0]             mism_s;
   logic                            busy_r, busy_s;
   logic                            done_r, done_s;
   logic                            pass_r, pass_s;

   // Two-flop synchroniser for the asynchronous chip responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= {CHANNELS{1'b0}};
         sync2_r <= {CHANNELS{1'b0}};
      end else begin
         sync1_r <= resp;
         sync2_r <= sync1_r;
      end
   end

   // Next-state, pattern sequencing and error accumulation
   always_comb begin
      state_s = state_r;
      stim_s  = stim_r;
      cnt_s   = cnt_r;
      mode_s  = mode_r;
      err_s   = err_r;
      diff_s  = diff_r;
      mism_s  = sync2_r ^ (mode_r ? ~stim_r : stim_r);
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_s = DRIVE;
               stim_s  = {CHANNELS{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
               mode_s  = invert;
               err_s   = {(CHANNELS*ERR_W){1'b0}};
               diff_s  = {CHANNELS{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         DRIVE: begin
            cnt_s = cnt_r + CNT_W'(32'd1);
            if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_s = SAMPLE;
            end else begin
               state_s = DRIVE;
            end
         end
         SAMPLE: begin
            diff_s = mism_s;
            for (int i = 0; i < CHANNELS; i++) begin
               if (mism_s[i] && (err_r[i] != ERR_MAX)) begin
                  err_s[i] = err_r[i] + ERR_W'(32'd1);
               end else begin
                  err_s[i] = err_r[i];
               end
            end
            // The last pattern parks at all-ones rather than wrapping
            if (stim_r != STIM_MAX) begin
               stim_s  = stim_r + CHANNELS'(32'd1);
               cnt_s   = {CNT_W{1'b0}};
               state_s = DRIVE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Registered status outputs derived from the upcoming state and counts
   always_comb begin
      fail_s = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         fail_s[i] = (err_s[i] >= ERR_W'(FAIL_THRESH));
      end
      busy_s = (state_s == DRIVE) || (state_s == SAMPLE);
      done_s = (state_s == DONE);
      pass_s = (state_s == DONE) && (err_s == {(CHANNELS*ERR_W){1'b0}});
   end

   // FSM and datapath state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         stim_r  <= {CHANNELS{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         mode_r  <= 1'b0;
         err_r   <= {(CHANNELS*ERR_W){1'b0}};
         fail_r  <= {CHANNELS{1'b0}};
         diff_r  <= {CHANNELS{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         stim_r  <= stim_s;
         cnt_r   <= cnt_s;
         mode_r  <= mode_s;
         err_r   <= err_s;
         fail_r  <= fail_s;
         diff_r  <= diff_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         pass_r  <= pass_s;
      end
   end

   assign stim      = stim_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign fail_flag = fail_r;
   assign diff      = diff_r;

endmodule

// File: tb/tb_gate_tester.sv
// Randomised self-checking bench for gate_tester with a pattern-sweep
// reference model and a second instance using a raised fail threshold.
module tb_gate_tester;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       invert;
   logic [5:0] resp, resp2;
   logic [5:0] stim, stim2;
   logic       busy, done, pass, busy2, done2, pass2;
   logic [5:0] fail_flag, diff, fail_flag2, diff2;

   logic [5:0] f_s0, f_s1, f_gp, f_gm;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   gate_tester dut (
      .clk(clk), .rst(rst), .start(start), .invert(invert), .resp(resp),
      .stim(stim), .busy(busy), .done(done), .pass(pass),
      .fail_flag(fail_flag), .diff(diff)
   );

   gate_tester #(.CHANNELS(6), .SETTLE_CYCLES(4), .ERR_W(4), .FAIL_THRESH(8)) dut2 (
      .clk(clk), .rst(rst), .start(start), .invert(invert), .resp(resp2),
      .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
      .fail_flag(fail_flag2), .diff(diff2)
   );

   // Chip under test: an inverter array with optional stuck bits and one glitchy pattern
   function automatic logic [5:0] model_resp(input logic [5:0] p);
      logic [5:0] r;
      r = (~p & ~f_s0) | f_s1;
      if (p == f_gp) r = r ^ f_gm;
      return r;
   endfunction

   always_comb resp  = model_resp(stim);
   always_comb resp2 = ~stim2 ^ {5'b00000, (stim2[5:1] == 5'b00000)};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_fault(input logic [5:0] s0, input logic [5:0] s1,
                            input logic [5:0] gp, input logic [5:0] gm);
      f_s0 = s0; f_s1 = s1; f_gp = gp; f_gm = gm;
   endtask

   // Start a run, optionally disturbing it, and check everything against the model
   task automatic run_and_check(input logic inv, input bit disturb);
      int n;
      bit bad;
      int exp_err [6];
      logic [5:0] exp_fail, m, e;
      for (int i = 0; i < 6; i++) exp_err[i] = 0;
      for (int p = 0; p < 64; p++) begin
         e = inv ? ~6'(p) : 6'(p);
         m = model_resp(6'(p)) ^ e;
         for (int i = 0; i < 6; i++)
            if (m[i] && exp_err[i] < 15) exp_err[i]++;
      end
      exp_fail = 6'h00;
      for (int i = 0; i < 6; i++) exp_fail[i] = (exp_err[i] >= 1);

      @(negedge clk);
      invert = inv;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      bad = 1'b0;
      while (!done && n < 2000) begin
         if (!busy || pass) bad = 1'b1;
         if (disturb) begin
            if (n == 50)  start  = 1'b1;
            if (n == 51)  start  = 1'b0;
            if (n == 120) invert = ~invert;
            if (n == 200) invert = ~invert;
         end
         @(negedge clk);
         n++;
      end
      check("run_len", n, 321);
      check("busy_during_run", bad, 1'b0);
      check("done", done, 1'b1);
      check("busy_at_done", busy, 1'b0);
      check("pass", pass, (exp_fail == 6'h00));
      check("fail_flag", fail_flag, exp_fail);
      check("stim_final", stim, 6'h3F);
      check("diff_final", diff, model_resp(6'h3F) ^ (inv ? 6'h00 : 6'h3F));
      for (int i = 0; i < 6; i++) check($sformatf("err%0d", i), dut.err_r[i], exp_err[i]);
      repeat (3) @(negedge clk);
      check("done_hold", {done, stim, fail_flag}, {1'b1, 6'h3F, exp_fail});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; invert = 1'b0;
      set_fault(6'h00, 6'h00, 6'h00, 6'h00);
      repeat (3) @(negedge clk);
      check("rst_outputs", {stim, busy, done, pass, fail_flag, diff}, 21'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_after_rst", {busy, done, stim}, 8'd0);

      // Healthy 7404 in inverting mode, plus the threshold-8 instance
      run_and_check(1'b1, 1'b0);
      check("7404_pass", {pass, fail_flag, stim}, {1'b1, 6'h00, 6'h3F});
      check("thr8_err0", dut2.err_r[0], 4'd2);
      check("thr8_fail", fail_flag2, 6'h00);
      check("thr8_pass_done", {pass2, done2}, 2'b01);

      // Healthy 7404 tested as a buffer: every pattern mismatches every channel
      run_and_check(1'b0, 1'b0);
      check("buf_fail", {pass, fail_flag}, {1'b0, 6'h3F});

      // resp[2] stuck low
      set_fault(6'h04, 6'h00, 6'h00, 6'h00);
      run_and_check(1'b1, 1'b0);
      check("stuck2_fail", {pass, fail_flag, dut.err_r[2]}, {1'b0, 6'h04, 4'd15});

      // Reset in the middle of a run aborts it completely
      @(negedge clk);
      invert = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_outputs", {stim, busy, done, pass, fail_flag, diff}, 21'd0);
      check("midrst_err2", dut.err_r[2], 4'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_idle", {busy, done}, 2'b00);
      run_and_check(1'b1, 1'b0);

      // Start and invert disturbances during a run change nothing
      set_fault(6'h00, 6'h00, 6'h00, 6'h00);
      run_and_check(1'b1, 1'b1);
      check("disturb_pass", pass, 1'b1);

      // Randomised fault patterns and modes
      for (int k = 0; k < 8; k++) begin
         if (k % 3 == 0)
            set_fault(6'h00, 6'h00, 6'h00, 6'h00);
         else
            set_fault(6'($urandom & $urandom & $urandom), 6'($urandom & $urandom & $urandom),
                      6'($urandom_range(0, 63)), 6'($urandom));
         run_and_check(1'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
